// File: rtl/time_counter.sv
// rtl/time_counter.sv - BCD HH:MM:SS time-of-day counter with 1 Hz prescaler and adjust inputs
// Tick advances the full carry chain; adjust pulses bump one field without carry.
module time_counter #(
  parameter int TICKS_PER_SEC = 31_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       adj_sec_pulse,
  input  logic       adj_min_pulse,
  input  logic       adj_hrs_pulse,
  output logic       sec_tick,
  output logic [1:0] hrs_d,
  output logic [3:0] hrs_u,
  output logic [2:0] min_d,
  output logic [3:0] min_u,
  output logic [2:0] sec_d,
  output logic [3:0] sec_u
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic          pend_sec, pend_min, pend_hrs;
  logic          wrap, app_sec, app_min, app_hrs;

  // {tens[2:0], units[3:0]} modulo 60
  function automatic logic [6:0] inc_60(input logic [6:0] v);
    logic [2:0] d;
    logic [3:0] u;
    d = v[6:4];
    u = v[3:0];
    if (u != 4'd9)
      return {d, u + 4'd1};
    else if (d != 3'd5)
      return {d + 3'd1, 4'd0};
    else
      return 7'd0;
  endfunction

  // {tens[1:0], units[3:0]} modulo 24
  function automatic logic [5:0] inc_24(input logic [5:0] v);
    logic [1:0] d;
    logic [3:0] u;
    d = v[5:4];
    u = v[3:0];
    if (d == 2'd2 && u == 4'd3)
      return 6'd0;
    else if (u == 4'd9)
      return {d + 2'd1, 4'd0};
    else
      return {d, u + 4'd1};
  endfunction

  // A pulse is applied immediately unless it collides with a tick, in which case it waits one cycle.
  always_comb begin
    wrap    = (presc == LAST);
    app_sec = (pend_sec | adj_sec_pulse) & ~wrap;
    app_min = (pend_min | adj_min_pulse) & ~wrap;
    app_hrs = (pend_hrs | adj_hrs_pulse) & ~wrap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      pend_sec <= 1'b0;
      pend_min <= 1'b0;
      pend_hrs <= 1'b0;
      hrs_d    <= '0;
      hrs_u    <= '0;
      min_d    <= '0;
      min_u    <= '0;
      sec_d    <= '0;
      sec_u    <= '0;
    end else begin
      sec_tick <= wrap;
      pend_sec <= (pend_sec | adj_sec_pulse) & wrap;
      pend_min <= (pend_min | adj_min_pulse) & wrap;
      pend_hrs <= (pend_hrs | adj_hrs_pulse) & wrap;
      presc    <= (wrap || app_sec) ? '0 : presc + PW'(1);
      if (wrap) begin
        {sec_d, sec_u} <= inc_60({sec_d, sec_u});
        if ({sec_d, sec_u} == 7'h59) begin
          {min_d, min_u} <= inc_60({min_d, min_u});
          if ({min_d, min_u} == 7'h59)
            {hrs_d, hrs_u} <= inc_24({hrs_d, hrs_u});
        end
      end else begin
        if (app_sec) {sec_d, sec_u} <= inc_60({sec_d, sec_u});
        if (app_min) {min_d, min_u} <= inc_60({min_d, min_u});
        if (app_hrs) {hrs_d, hrs_u} <= inc_24({hrs_d, hrs_u});
      end
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// tb/tb_time_counter.sv - directed bench for time_counter with an integer reference model and scoreboard
module tb_time_counter;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       adj_sec_pulse = 1'b0, adj_min_pulse = 1'b0, adj_hrs_pulse = 1'b0;
  logic       sec_tick;
  logic [1:0] hrs_d;
  logic [3:0] hrs_u, min_u, sec_u;
  logic [2:0] min_d, sec_d;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state (plain integers)
  int m_presc, m_h, m_m, m_s;
  bit m_ps, m_pm, m_ph, m_tick;
  logic [20:0] sb_q[$];

  time_counter #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .adj_sec_pulse(adj_sec_pulse), .adj_min_pulse(adj_min_pulse), .adj_hrs_pulse(adj_hrs_pulse),
    .sec_tick(sec_tick), .hrs_d(hrs_d), .hrs_u(hrs_u), .min_d(min_d), .min_u(min_u),
    .sec_d(sec_d), .sec_u(sec_u)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] bcd(input bit t, input int h, input int m, input int s);
    return {t, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [20:0] obs_vec();
    return {sec_tick, hrs_d, hrs_u, min_d, min_u, sec_d, sec_u};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_presc = 0; m_h = 0; m_m = 0; m_s = 0;
    m_ps = 0; m_pm = 0; m_ph = 0; m_tick = 0;
  endtask

  task automatic m_step(input bit a_s, input bit a_m, input bit a_h);
    bit es, em, eh;
    es = m_ps | a_s; em = m_pm | a_m; eh = m_ph | a_h;
    if (m_presc == T - 1) begin
      m_tick = 1; m_presc = 0;
      m_s++;
      if (m_s == 60) begin
        m_s = 0; m_m++;
        if (m_m == 60) begin m_m = 0; m_h = (m_h + 1) % 24; end
      end
      m_ps = es; m_pm = em; m_ph = eh;
    end else begin
      m_tick = 0; m_presc++;
      if (es) begin m_s = (m_s + 1) % 60; m_presc = 0; end
      if (em) m_m = (m_m + 1) % 60;
      if (eh) m_h = (m_h + 1) % 24;
      m_ps = 0; m_pm = 0; m_ph = 0;
    end
    sb_q.push_back(bcd(m_tick, m_h, m_m, m_s));
  endtask

  // one clock: drive pulses, predict, then compare after the edge
  task automatic cycle(input bit a_s, input bit a_m, input bit a_h);
    logic [20:0] exp;
    adj_sec_pulse = a_s; adj_min_pulse = a_m; adj_hrs_pulse = a_h;
    m_step(a_s, a_m, a_h);
    @(posedge clk); #1;
    adj_sec_pulse = 0; adj_min_pulse = 0; adj_hrs_pulse = 0;
    if (sb_q.size() == 0) chk("scoreboard_empty", 0, 1);
    else begin
      exp = sb_q.pop_front();
      chk_vec("scoreboard", obs_vec(), exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    int n = 0;
    while ((m_h != h || m_m != m || m_s != s || m_ps || m_pm || m_ph) && n < 400) begin
      cycle(m_s != s && !m_ps, m_m != m && !m_pm, m_h != h && !m_ph);
      n++;
    end
    chk("set_time_bound", int'(n < 400), 1);
  endtask

  task automatic cycles_to_tick(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(0, 0, 0);
      if (sec_tick === 1'b1) begin n = i; break; end
    end
  endtask

  initial begin
    int ticks, first, n;
    m_reset();

    // reset state
    @(posedge clk); #1;
    chk_vec("reset_state", obs_vec(), 21'd0);
    reset_n = 1'b1;

    // 1: free run 80 cycles
    ticks = 0; first = 0;
    for (int i = 1; i <= 80; i++) begin
      cycle(0, 0, 0);
      if (sec_tick === 1'b1) begin
        ticks++;
        if (first == 0) first = i;
      end
    end
    chk("t1_tick_count", ticks, 10);
    chk("t1_first_tick", first, 8);
    chk("t1_sec_d", int'(sec_d), 1);
    chk("t1_sec_u", int'(sec_u), 0);

    // 2: 23:59:59 rolls to 00:00:00 on the tick
    set_time(23, 59, 59);
    chk_vec("t2_before", obs_vec() & 21'h0FFFFF, bcd(0, 23, 59, 59));
    cycles_to_tick(n);
    chk("t2_tick_seen", int'(n != 0), 1);
    chk_vec("t2_rollover", obs_vec(), bcd(1, 0, 0, 0));

    // 3: adj_sec at 00:00:59 wraps without carry and restarts the prescaler
    set_time(0, 0, 59);
    cycle(1, 0, 0);
    chk_vec("t3_sec_wrap", obs_vec(), bcd(0, 0, 0, 0));
    cycles_to_tick(n);
    chk("t3_next_tick", n, 8);

    // 4: hours adjust 23->00 and 09->10, minutes untouched
    set_time(23, 10, 20);
    cycle(0, 0, 1);
    chk("t4_hrs_23_wrap", int'({hrs_d, hrs_u}), 0);
    chk("t4_min_kept", int'({min_d, min_u}), 8'h10);
    set_time(9, 30, 0);
    cycle(0, 0, 1);
    chk("t4_hrs_09_to_10", int'({hrs_d, hrs_u}), 8'h10);
    chk("t4_min_kept2", int'({min_d, min_u}), 8'h30);

    // 5: adj_min collides with the tick at 00:05:59
    set_time(0, 5, 59);
    n = 0;
    while (m_presc != T - 1 && n < 20) begin cycle(0, 0, 0); n++; end
    chk_vec("t5_before", obs_vec() & 21'h0FFFFF, bcd(0, 0, 5, 59));
    cycle(0, 1, 0);
    chk_vec("t5_tick_first", obs_vec(), bcd(1, 0, 6, 0));
    cycle(0, 0, 0);
    chk_vec("t5_adj_after", obs_vec(), bcd(0, 0, 7, 0));

    // 6: asynchronous reset mid-count
    set_time(12, 34, 56);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    #3 reset_n = 1'b0;
    #1 chk_vec("t6_async_reset", obs_vec(), 21'd0);
    m_reset();
    adj_sec_pulse = 1; adj_min_pulse = 1; adj_hrs_pulse = 1;
    @(posedge clk); #1;
    adj_sec_pulse = 0; adj_min_pulse = 0; adj_hrs_pulse = 0;
    chk_vec("t6_pulses_dropped", obs_vec(), 21'd0);
    reset_n = 1'b1;
    cycles_to_tick(n);
    chk("t6_first_tick", n, 8);
    chk_vec("t6_time", obs_vec(), bcd(1, 0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
